// File: rtl/ntt_pkg.sv
// Shared constants, pipeline latencies and controller state encoding for the NTT datapath.
// Pure declarations; no latency and no flow control of its own.
package ntt_pkg;

    localparam int N       = 256;
    localparam int LOG_N   = 8;
    localparam int Q       = 8380417;
    localparam int RD_LAT  = 1;
    localparam int BFU_LAT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } ntt_state_t;

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register carrying write enable/addresses; output is input delayed DEPTH cycles.
// No backpressure: shifts every cycle, and reset empties every stage.
module ntt_delay_line #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// NTT/INTT layer sequencer: one butterfly pair per cycle, writes RD_LAT+BFU_LAT cycles after reads.
// No backpressure: the RAM and butterfly unit are assumed to accept one pair every cycle.
module ntt_ctrl #(
    parameter int N       = ntt_pkg::N,
    parameter int RD_LAT  = ntt_pkg::RD_LAT,
    parameter int BFU_LAT = ntt_pkg::BFU_LAT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_intt,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_rd_en,
    output logic [7:0] o_rd_addr_a,
    output logic [7:0] o_rd_addr_b,
    output logic [7:0] o_tw_idx,
    output logic       o_bfu_intt,
    output logic       o_wr_en,
    output logic [7:0] o_wr_addr_a,
    output logic [7:0] o_wr_addr_b
);

    import ntt_pkg::*;

    localparam int DLY = RD_LAT + BFU_LAT;
    localparam int DCW = (DLY > 1) ? $clog2(DLY) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DLY - 1);
    localparam logic [6:0]     P_LAST     = 7'(N / 2 - 1);
    localparam logic [2:0]     L_LAST     = 3'(LOG_N - 1);

    ntt_state_t     state, state_nxt;
    logic [2:0]     layer;
    logic [6:0]     p, off, blk;
    logic [7:0]     base, len;
    logic [DCW-1:0] drain_cnt;
    logic           intt_q;
    logic           drain_end, last_in_block;
    logic [7:0]     addr_a, addr_b, tw_raw;
    logic [16:0]    wr_dat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    assign drain_end = (drain_cnt == DRAIN_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (i_start) state_nxt = S_RUN;
            S_RUN:   if (p == P_LAST) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_end) state_nxt = (layer == L_LAST) ? S_DONE : S_RUN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Blocks are walked with offset/block/base counters so no divide or modulo is needed.
    assign len           = intt_q ? (8'd1 << layer) : (8'd128 >> layer);
    assign last_in_block = ({1'b0, off} == len - 8'd1);
    assign addr_a        = base + {1'b0, off};
    assign addr_b        = addr_a + len;
    assign tw_raw        = intt_q ? ((8'hFF >> layer) - {1'b0, blk})
                                  : ((8'd1 << layer) + {1'b0, blk});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            layer     <= '0;
            p         <= '0;
            off       <= '0;
            blk       <= '0;
            base      <= '0;
            drain_cnt <= '0;
            intt_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        intt_q <= i_intt;
                        layer  <= '0;
                    end
                end
                S_RUN: begin
                    p <= p + 7'd1;
                    if (p == P_LAST) begin
                        off  <= '0;
                        blk  <= '0;
                        base <= '0;
                    end else if (last_in_block) begin
                        off  <= '0;
                        blk  <= blk + 7'd1;
                        base <= base + {len[6:0], 1'b0};
                    end else begin
                        off <= off + 7'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_end) begin
                        drain_cnt <= '0;
                        layer     <= layer + 3'd1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);
    assign o_rd_en     = (state == S_RUN);
    assign o_rd_addr_a = o_rd_en ? addr_a : 8'd0;
    assign o_rd_addr_b = o_rd_en ? addr_b : 8'd0;
    assign o_tw_idx    = o_rd_en ? tw_raw : 8'd0;
    assign o_bfu_intt  = intt_q;

    ntt_delay_line #(
        .DEPTH (DLY),
        .WIDTH (17)
    ) u_wr_dly (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .din   ({o_rd_en, o_rd_addr_a, o_rd_addr_b}),
        .dout  (wr_dat)
    );

    assign {o_wr_en, o_wr_addr_a, o_wr_addr_b} = wr_dat;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Randomized bench for ntt_ctrl: cycle-level schedule model plus RAM/butterfly model
// checked against reference forward/inverse NTT loops mod Q.
module tb_ntt_ctrl;

    localparam longint QL    = longint'(ntt_pkg::Q);
    localparam int     LAT   = 5;
    localparam int     PER   = 128 + LAT;
    localparam int     TOTAL = 8 * PER;

    logic       i_clk = 1'b0;
    logic       i_rst_n, i_start, i_intt;
    logic       o_busy, o_done, o_rd_en, o_bfu_intt, o_wr_en;
    logic [7:0] o_rd_addr_a, o_rd_addr_b, o_tw_idx, o_wr_addr_a, o_wr_addr_b;

    ntt_ctrl dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_intt      (i_intt),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rd_en     (o_rd_en),
        .o_rd_addr_a (o_rd_addr_a),
        .o_rd_addr_b (o_rd_addr_b),
        .o_tw_idx    (o_tw_idx),
        .o_bfu_intt  (o_bfu_intt),
        .o_wr_en     (o_wr_en),
        .o_wr_addr_a (o_wr_addr_a),
        .o_wr_addr_b (o_wr_addr_b)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        longint va;
        longint vb;
        int     a;
        int     b;
    } wr_t;

    int     total = 0;
    int     bad   = 0;
    bit     m_act = 1'b0;
    int     m_k   = 0;
    bit     m_intt = 1'b0;
    int     cyc = 0;
    int     first_rd = -1;
    int     done_cnt = 0;
    longint ram  [256];
    longint refp [256];
    longint zeta [256];
    wr_t    pend [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint addq(input longint x, input longint y);
        return (x + y) % QL;
    endfunction

    function automatic longint subq(input longint x, input longint y);
        return (x - y + QL) % QL;
    endfunction

    function automatic longint mulq(input longint x, input longint y);
        return (x * y) % QL;
    endfunction

    function automatic longint modpow(input longint b, input int e);
        longint r, x;
        r = 1;
        x = b % QL;
        for (int i = 0; i < 32; i++) begin
            if (((e >> i) & 1) == 1) r = mulq(r, x);
            x = mulq(x, x);
        end
        return r;
    endfunction

    function automatic int brv8(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    // Pair p of layer l, straight from the block/offset definition.
    function automatic void pair_of(input bit intt, input int l, input int p,
                                    output int a, output int b, output int tw);
        int len, blk, off;
        len = intt ? (1 << l) : (128 >> l);
        blk = p / len;
        off = p % len;
        a   = 2 * len * blk + off;
        b   = a + len;
        tw  = intt ? (2 * (128 / len) - 1 - blk) : (128 / len + blk);
    endfunction

    function automatic logic [44:0] outs();
        return {o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx,
                o_bfu_intt, o_wr_en, o_wr_addr_a, o_wr_addr_b};
    endfunction

    function automatic logic [44:0] expect_out(input bit act, input int k, input bit intt);
        logic       rd, wr;
        logic [7:0] ra, rb, t, wa, wb;
        int         a, b, tw, j;
        rd = 1'b0; wr = 1'b0;
        ra = '0; rb = '0; t = '0; wa = '0; wb = '0;
        if (act && k < TOTAL && (k % PER) < 128) begin
            pair_of(intt, k / PER, k % PER, a, b, tw);
            rd = 1'b1; ra = 8'(a); rb = 8'(b); t = 8'(tw);
        end
        j = k - LAT;
        if (act && j >= 0 && j < TOTAL && (j % PER) < 128) begin
            pair_of(intt, j / PER, j % PER, a, b, tw);
            wr = 1'b1; wa = 8'(a); wb = 8'(b);
        end
        return {act, act && (k == TOTAL), rd, ra, rb, t, intt, wr, wa, wb};
    endfunction

    task automatic ref_ntt();
        int     k;
        longint t;
        k = 0;
        for (int len = 128; len > 0; len >>= 1)
            for (int st = 0; st < 256; st += 2 * len) begin
                k++;
                for (int j = st; j < st + len; j++) begin
                    t = mulq(zeta[k], refp[j+len]);
                    refp[j+len] = subq(refp[j], t);
                    refp[j]     = addq(refp[j], t);
                end
            end
    endtask

    task automatic ref_invntt();
        int     k;
        longint t, z;
        k = 256;
        for (int len = 1; len < 256; len <<= 1)
            for (int st = 0; st < 256; st += 2 * len) begin
                k--;
                z = subq(0, zeta[k]);
                for (int j = st; j < st + len; j++) begin
                    t = refp[j];
                    refp[j]     = addq(t, refp[j+len]);
                    refp[j+len] = mulq(subq(t, refp[j+len]), z);
                end
            end
    endtask

    task automatic tick(input bit st, input bit iv);
        wr_t    w;
        longint x, y, z, t;
        i_start = st;
        i_intt  = iv;
        @(posedge i_clk);
        cyc++;
        if (!m_act) begin
            if (st) begin m_act = 1'b1; m_k = 0; m_intt = iv; end
        end else begin
            m_k++;
            if (m_k > TOTAL) m_act = 1'b0;
        end
        @(negedge i_clk);
        check_eq("outputs", outs(), expect_out(m_act, m_k, m_intt));

        if (m_act && !m_intt && m_k == 0)
            check_eq("ntt_first", {o_rd_addr_a, o_rd_addr_b, o_tw_idx}, {8'd0, 8'd128, 8'd1});
        if (m_act && !m_intt && m_k == 127)
            check_eq("ntt_l0_last", {o_rd_addr_a, o_rd_addr_b, o_tw_idx}, {8'd127, 8'd255, 8'd1});
        if (m_act && !m_intt && m_k == PER)
            check_eq("ntt_l1_first", {o_rd_addr_a, o_rd_addr_b, o_tw_idx}, {8'd0, 8'd64, 8'd2});
        if (m_act && m_intt && m_k == 0)
            check_eq("intt_first", {o_rd_addr_a, o_rd_addr_b, o_tw_idx}, {8'd0, 8'd1, 8'd255});
        if (m_act && m_intt && m_k == 1)
            check_eq("intt_p1", {o_rd_addr_a, o_rd_addr_b, o_tw_idx}, {8'd2, 8'd3, 8'd254});
        if (m_act && m_intt && m_k == 7 * PER + 127)
            check_eq("intt_l7_last", {o_rd_addr_a, o_rd_addr_b, o_tw_idx}, {8'd127, 8'd255, 8'd1});

        if (o_rd_en && first_rd < 0) first_rd = cyc;
        if (o_done) begin
            done_cnt++;
            check_eq("done_lat", 64'(cyc - first_rd), 64'(TOTAL));
            first_rd = -1;
        end

        // Read before write: a same-cycle hazard would see stale data.
        if (o_rd_en) begin
            x = ram[o_rd_addr_a];
            y = ram[o_rd_addr_b];
            z = zeta[o_tw_idx];
            if (o_bfu_intt) begin
                w.va = addq(x, y);
                w.vb = mulq(subq(x, y), subq(0, z));
            end else begin
                t    = mulq(z, y);
                w.va = addq(x, t);
                w.vb = subq(x, t);
            end
            w.a = int'(o_rd_addr_a);
            w.b = int'(o_rd_addr_b);
            pend.push_back(w);
        end
        if (o_wr_en) begin
            check_eq("wr_has_read", 64'(pend.size() > 0), 64'd1);
            if (pend.size() > 0) begin
                w = pend.pop_front();
                check_eq("wr_pair", {o_wr_addr_a, o_wr_addr_b}, {8'(w.a), 8'(w.b)});
                ram[o_wr_addr_a] = w.va;
                ram[o_wr_addr_b] = w.vb;
            end
        end
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        #1;
        check_eq("rst_outputs", outs(), 45'd0);
        m_act    = 1'b0;
        m_intt   = 1'b0;
        first_rd = -1;
        pend.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic run_xform(input bit intt, input int spam_k, input int rst_k);
        int guard;
        done_cnt = 0;
        guard    = 0;
        tick(1'b1, intt);
        while (m_act && guard < TOTAL + 50) begin
            if (m_k == rst_k) begin
                apply_reset();
                return;
            end
            tick((m_k == spam_k) || ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
            guard++;
        end
        check_eq("done_cnt", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) zeta[k] = modpow(1753, brv8(k));
        i_rst_n = 1'b1;
        i_start = 1'b0;
        i_intt  = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("rst_outputs", outs(), 45'd0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) tick(1'b0, 1'($urandom_range(0, 1)));

        for (int i = 0; i < 256; i++) begin
            ram[i]  = longint'($urandom_range(0, ntt_pkg::Q - 1));
            refp[i] = ram[i];
        end
        ref_ntt();
        run_xform(1'b0, 300, -1);
        for (int i = 0; i < 256; i++) check_eq($sformatf("ntt_coef%0d", i), ram[i], refp[i]);

        for (int i = 0; i < 256; i++) begin
            ram[i]  = longint'($urandom_range(0, ntt_pkg::Q - 1));
            refp[i] = ram[i];
        end
        ref_invntt();
        run_xform(1'b1, -1, -1);
        for (int i = 0; i < 256; i++) check_eq($sformatf("intt_coef%0d", i), ram[i], refp[i]);

        done_cnt = 0;
        run_xform(1'($urandom_range(0, 1)), 300, 500);
        repeat (20) tick(1'b0, 1'($urandom_range(0, 1)));
        check_eq("post_rst_done", 64'(done_cnt), 64'd0);

        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(0, 3)) tick(1'b0, 1'($urandom_range(0, 1)));
            run_xform(1'($urandom_range(0, 1)), $urandom_range(1, 1000), -1);
        end
        repeat (8) tick(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 SHALL have parameter N, default 256, meaning the number of coefficients per polynomial.
REQ-002 SHALL have parameter RD_LAT, default 1, meaning the coefficient RAM read latency in cycles.
REQ-003 SHALL have parameter BFU_LAT, default 4, meaning the butterfly unit input-to-output latency in cycles.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_start, input, 1 bit: a transform request, sampled only in IDLE.
REQ-007 SHALL have port i_intt, input, 1 bit: 1 selects inverse NTT, 0 selects forward; latched at start.
REQ-008 SHALL have port o_busy, output, 1 bit: high in every state other than IDLE.
REQ-009 SHALL have port o_done, output, 1 bit: a 1-cycle completion pulse.
REQ-010 SHALL have port o_rd_en, output, 1 bit, and ports o_rd_addr_a / o_rd_addr_b, output, 8 bits each: the coefficient pair read request.
REQ-011 SHALL have port o_tw_idx, output, 8 bits: the zeta ROM index issued alongside the read.
REQ-012 SHALL have port o_bfu_intt, output, 1 bit: the butterfly mode, equal to the latched i_intt.
REQ-013 SHALL have port o_wr_en, output, 1 bit, and ports o_wr_addr_a / o_wr_addr_b, output, 8 bits each: butterfly result write-back.

Function
REQ-014 SHALL implement the FSM IDLE -> RUN -> DRAIN -> (RUN for the next layer | DONE) -> IDLE.
REQ-015 SHALL move from IDLE to RUN on i_start=1; layer=0 and pair p=0 at entry.
REQ-016 SHALL define len per layer l (0..7): NTT len = 128>>l; INTT len = 1<<l.
REQ-017 SHALL, in RUN, issue exactly one pair per cycle for p=0..127 with o_rd_en=1.
- block = p/len, off = p%len.
- addr_a = 2*len*block + off; addr_b = addr_a + len.
- Pair addressing SHALL use incrementing counters, not dividers.
REQ-018 SHALL compute o_tw_idx as follows:
- NTT: (128/len) + block.
- INTT: 2*(128/len) - 1 - block.
REQ-019 SHALL move from RUN to DRAIN after p=127 is issued.
REQ-020 SHALL hold DRAIN for RD_LAT+BFU_LAT cycles with o_rd_en=0, then exit:
- to RUN with layer+1 and p=0 when layer<7;
- otherwise to DONE.
REQ-021 SHALL delay each issued read by exactly RD_LAT+BFU_LAT cycles (5 at defaults) to the matching write:
- o_wr_en asserts that many cycles after o_rd_en;
- o_wr_addr_a / o_wr_addr_b equal the delayed o_rd_addr_a / o_rd_addr_b.
REQ-022 SHALL ensure the first read of layer l+1 occurs at least one cycle after the last write of layer l (no read-after-write hazard).
REQ-023 SHALL pulse o_done for one cycle in DONE, which is the cycle after the final o_wr_en, then return to IDLE.
REQ-024 SHALL take 8*(128+5)=1064 cycles at defaults from the first o_rd_en to the o_done pulse.
REQ-025 SHALL ignore i_start while o_busy=1; it SHALL ignore i_intt changes after start.
REQ-026 SHALL accept i_start in the cycle after o_done, beginning a new transform.
REQ-027 SHALL drive o_rd_addr_*, o_tw_idx and o_wr_addr_* to 0 whenever the corresponding enable is 0.
REQ-028 SHALL NOT perform the INTT final scaling by 41978 (mont^2/256); that is a separate stage.

Reset
REQ-029 SHALL, on i_rst_n=0, immediately force:
- state to IDLE;
- layer, p and the drain counter to 0;
- the write delay line to empty;
- all outputs to 0.
REQ-030 SHALL, on reset mid-transform, abandon the transform: no o_wr_en and no o_done after reset release until a new i_start.

Structure
REQ-031 SHALL take N, LOG_N=8, Q=8380417, the pipeline latency constants and the FSM state enum from the shared package ntt_pkg.
REQ-032 SHALL implement the write-address/enable delay as a sub-module ntt_delay_line, parameterised by depth and width.

Verification
REQ-033 SHALL cover NTT start: the first pair is addr 0/128 with tw_idx 1; p=127 of layer 0 is 127/255 with tw_idx 1; the first pair of layer 1 is 0/64 with tw_idx 2.
REQ-034 SHALL cover INTT start: the first pair is 0/1 with tw_idx 255; p=1 is 2/3 with tw_idx 254; the last pair of layer 7 is 127/255 with tw_idx 1.
REQ-035 SHALL cover write timing: every o_wr_en occurs exactly 5 cycles after its o_rd_en with identical addresses; o_done comes 1064 cycles after the first o_rd_en.
REQ-036 SHALL cover start-while-busy: a second i_start pulsed at cycle 300 causes no restart, and exactly one o_done is produced.
REQ-037 SHALL cover reset at cycle 500: all outputs are 0 within the reset cycle; there is no o_wr_en or o_done afterward; the next i_start runs a full 1064-cycle transform.
REQ-038 SHALL cover end-to-end: controller + RAM model + butterfly unit on a random polynomial match the C reference poly_ntt / poly_invntt_tomont (pre-scaling) output coefficient-for-coefficient mod Q.
